// File: rtl/hdmi_timing_pkg.sv
// hdmi_timing_pkg: shared HDMI period-mode encoding, island FSM states and
// control-period / guard-band constants used by the data island scheduler.
// Also provides the packets-per-island calculation used at elaboration time.
package hdmi_timing_pkg;

  // TMDS period mode, shared with the downstream encoder mux
  typedef enum logic [2:0] {
    MODE_CTRL            = 3'd0,
    MODE_VIDEO_PREAMBLE  = 3'd1,
    MODE_VIDEO_GUARD     = 3'd2,
    MODE_VIDEO_DATA      = 3'd3,
    MODE_ISLAND_PREAMBLE = 3'd4,
    MODE_ISLAND_GUARD    = 3'd5,
    MODE_ISLAND_DATA     = 3'd6
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_LEAD_GUARD,
    S_DATA,
    S_TRAIL_GUARD
  } isl_state_t;

  localparam int CTRL_MIN   = 12;
  localparam int PREAMBLE   = 8;
  localparam int GUARD      = 2;
  localparam int PACKET_LEN = 32;

  // Packets that fit in horizontal blanking once both control minima,
  // both preambles and the three guard bands are reserved. Clamped at 0
  // so a narrow blanking interval simply disables islands.
  function automatic int calc_num_packets(input int fw, input int sw, input int maxp);
    int room;
    room = fw - sw - 2*CTRL_MIN - 2*PREAMBLE - 3*GUARD;
    if (room < 0) room = 0;
    room = room / PACKET_LEN;
    return (room > maxp) ? maxp : room;
  endfunction

endpackage

// File: rtl/data_island_scheduler_island_sequencer.sv
// island_sequencer: data island FSM with period and slot counters.
// Ports:
//   clk_pixel, reset_n  pixel clock, async active-low reset
//   start               one-cycle request to open an island (cx-triggered)
//   active              island in progress (state != S_IDLE)
//   island_mode         mode for the pixel currently presented
//   packet_load         cycle before each packet's first data pixel
//   pixel_idx           pixel index inside the current packet, 0 outside data
// The state register tracks the pixel currently on cx; outputs here are
// combinational from state and are registered by the top level.
module island_sequencer
  import hdmi_timing_pkg::*;
#(
  parameter int NUM_PACKETS = 3
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       start,
  output logic       active,
  output mode_t      island_mode,
  output logic       packet_load,
  output logic [4:0] pixel_idx
);

  localparam logic [4:0] LAST_PRE   = 5'(PREAMBLE - 1);
  localparam logic [4:0] LAST_GUARD = 5'(GUARD - 1);
  localparam logic [4:0] LAST_PIX   = 5'(PACKET_LEN - 1);
  localparam logic [4:0] LAST_PKT   = (NUM_PACKETS > 0) ? 5'(NUM_PACKETS - 1) : 5'd0;

  isl_state_t state;
  logic [4:0] cnt;   // cycles within preamble/guard, or pixel within packet
  logic [4:0] pkt;   // packet index within the island

  // Once opened, the island runs on its own counters; cx jumps and
  // island_enable changes are ignored until it returns to idle.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pkt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          pkt <= '0;
          if (start) state <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          if (cnt == LAST_PRE) begin
            state <= S_LEAD_GUARD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_LEAD_GUARD: begin
          if (cnt == LAST_GUARD) begin
            state <= S_DATA;
            cnt   <= '0;
            pkt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_DATA: begin
          if (cnt == LAST_PIX) begin
            cnt <= '0;
            if (pkt == LAST_PKT) state <= S_TRAIL_GUARD;
            else                 pkt   <= pkt + 5'd1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_TRAIL_GUARD: begin
          if (cnt == LAST_GUARD) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          pkt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    active      = (state != S_IDLE);
    island_mode = MODE_CTRL;
    packet_load = 1'b0;
    pixel_idx   = '0;
    case (state)
      S_PREAMBLE:    island_mode = MODE_ISLAND_PREAMBLE;
      S_LEAD_GUARD: begin
        island_mode = MODE_ISLAND_GUARD;
        packet_load = (cnt == LAST_GUARD);
      end
      S_DATA: begin
        island_mode = MODE_ISLAND_DATA;
        pixel_idx   = cnt;
        // next packet loads at the end of every packet except the last
        packet_load = (cnt == LAST_PIX) && (pkt != LAST_PKT);
      end
      S_TRAIL_GUARD: island_mode = MODE_ISLAND_GUARD;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_island_scheduler.sv
// data_island_scheduler: decodes timing-generator cx/cy into the TMDS period
// mode and schedules HDMI data islands in horizontal blanking.
// Ports:
//   clk_pixel, reset_n     pixel clock, async active-low reset
//   cx, cy                 current column / line
//   island_enable          permit data islands (0 = DVI), sampled at trigger column
//   mode                   period mode (hdmi_timing_pkg::mode_t encoding)
//   packet_enable          one-cycle pulse: load next packet
//   packet_pixel_counter   pixel index within the current packet
//   video_field_end        one-cycle pulse after the frame's last pixel
//   island_packet_count    (HDMI_ISLAND_STATS_EN only) packets in last frame
// All outputs are registered: they describe the cx/cy sampled on the
// previous clock edge.
// Optional feature macro: HDMI_ISLAND_STATS_EN.
module data_island_scheduler
  import hdmi_timing_pkg::*;
#(
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BIT_WIDTH     = 10,
  parameter int BIT_HEIGHT    = 10,
  parameter int MAX_PACKETS   = 18
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic                  island_enable,
  output logic [2:0]            mode,
  output logic                  packet_enable,
  output logic [4:0]            packet_pixel_counter,
`ifdef HDMI_ISLAND_STATS_EN
  output logic                  video_field_end,
  output logic [15:0]           island_packet_count
`else
  output logic                  video_field_end
`endif
);

  localparam int NUM_PACKETS = calc_num_packets(FRAME_WIDTH, SCREEN_WIDTH, MAX_PACKETS);

  localparam logic [BIT_WIDTH-1:0]  CX_TRIG    = BIT_WIDTH'(SCREEN_WIDTH + CTRL_MIN - 1);
  localparam logic [BIT_WIDTH-1:0]  CX_ACTIVE  = BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [BIT_WIDTH-1:0]  CX_VPRE_LO = BIT_WIDTH'(FRAME_WIDTH - 10);
  localparam logic [BIT_WIDTH-1:0]  CX_VPRE_HI = BIT_WIDTH'(FRAME_WIDTH - 3);
  localparam logic [BIT_WIDTH-1:0]  CX_VGRD_LO = BIT_WIDTH'(FRAME_WIDTH - 2);
  localparam logic [BIT_WIDTH-1:0]  CX_LAST    = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_HEIGHT-1:0] CY_ACTIVE  = BIT_HEIGHT'(SCREEN_HEIGHT);
  localparam logic [BIT_HEIGHT-1:0] CY_PRELAST = BIT_HEIGHT'(SCREEN_HEIGHT - 1);
  localparam logic [BIT_HEIGHT-1:0] CY_LAST    = BIT_HEIGHT'(FRAME_HEIGHT - 1);

  logic       isl_start;
  logic       isl_active;
  mode_t      isl_mode;
  logic       isl_load;
  logic [4:0] isl_pix;
  logic       next_line_active;
  mode_t      next_mode;

  // Island start depends only on the column; every line, blanking included.
  assign isl_start = (NUM_PACKETS >= 1) && island_enable && (cx == CX_TRIG);

  island_sequencer #(
    .NUM_PACKETS (NUM_PACKETS)
  ) u_seq (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .start       (isl_start),
    .active      (isl_active),
    .island_mode (isl_mode),
    .packet_load (isl_load),
    .pixel_idx   (isl_pix)
  );

  // Video preamble/guard at the end of a line only lead into an active line;
  // the last frame line leads into line 0.
  assign next_line_active = (cy < CY_PRELAST) || (cy == CY_LAST);

  always_comb begin
    next_mode = MODE_CTRL;
    if (cx < CX_ACTIVE && cy < CY_ACTIVE)
      next_mode = MODE_VIDEO_DATA;
    else if (isl_active)
      next_mode = isl_mode;
    else if (next_line_active && cx >= CX_VPRE_LO && cx <= CX_VPRE_HI)
      next_mode = MODE_VIDEO_PREAMBLE;
    else if (next_line_active && cx >= CX_VGRD_LO)
      next_mode = MODE_VIDEO_GUARD;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      mode                 <= MODE_CTRL;
      packet_enable        <= 1'b0;
      packet_pixel_counter <= '0;
      video_field_end      <= 1'b0;
    end else begin
      mode                 <= next_mode;
      packet_enable        <= isl_load;
      packet_pixel_counter <= isl_pix;
      video_field_end      <= (cx == CX_LAST) && (cy == CY_LAST);
    end
  end

`ifdef HDMI_ISLAND_STATS_EN
  logic [15:0] pkt_cnt;

  // video_field_end never coincides with packet_enable, so clearing on it
  // cannot drop a pulse.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt             <= '0;
      island_packet_count <= '0;
    end else if (video_field_end) begin
      island_packet_count <= pkt_cnt;
      pkt_cnt             <= '0;
    end else if (packet_enable) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_island_scheduler.sv
module tb_data_island_scheduler;
  import hdmi_timing_pkg::*;

  logic       clk_pixel = 1'b0;
  logic       reset_n   = 1'b0;
  logic [9:0] cx        = '0;
  logic [9:0] cy        = '0;
  logic       island_enable = 1'b1;

  logic [2:0] mode;
  logic       packet_enable;
  logic [4:0] packet_pixel_counter;
  logic       video_field_end;
  logic [2:0] n_mode;
  logic       n_pe;
  logic [4:0] n_ppc;
  logic       n_vfe;
`ifdef HDMI_ISLAND_STATS_EN
  logic [15:0] island_packet_count;
  logic [15:0] n_ipc;
`endif

  always #5 clk_pixel = ~clk_pixel;

  data_island_scheduler u_dut (
    .clk_pixel            (clk_pixel),
    .reset_n              (reset_n),
    .cx                   (cx),
    .cy                   (cy),
    .island_enable        (island_enable),
    .mode                 (mode),
    .packet_enable        (packet_enable),
    .packet_pixel_counter (packet_pixel_counter),
`ifdef HDMI_ISLAND_STATS_EN
    .island_packet_count  (island_packet_count),
`endif
    .video_field_end      (video_field_end)
  );

  // Blanking too narrow for a single packet: islands must never open.
  data_island_scheduler #(.FRAME_WIDTH(700), .SCREEN_WIDTH(640)) u_narrow (
    .clk_pixel            (clk_pixel),
    .reset_n              (reset_n),
    .cx                   (cx),
    .cy                   (cy),
    .island_enable        (island_enable),
    .mode                 (n_mode),
    .packet_enable        (n_pe),
    .packet_pixel_counter (n_ppc),
`ifdef HDMI_ISLAND_STATS_EN
    .island_packet_count  (n_ipc),
`endif
    .video_field_end      (n_vfe)
  );

  typedef struct packed {
    logic [2:0] mode;
    logic       pe;
    logic [4:0] ppc;
    logic       vfe;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   narrow_bad = 0;

  always @(negedge clk_pixel)
    if (n_pe || n_mode >= 3'd4 || n_ppc != 5'd0) narrow_bad++;

  // Reference for the 800x525 default: 3 packets, island columns 652..759.
  function automatic obs_t model(input int x, input int y, input bit isl);
    obs_t e;
    bit   nla;
    e      = '0;
    e.mode = MODE_CTRL;
    nla    = (y < 479) || (y == 524);
    if (x < 640 && y < 480)                               e.mode = MODE_VIDEO_DATA;
    else if (isl && x >= 652 && x <= 659)                 e.mode = MODE_ISLAND_PREAMBLE;
    else if (isl && (x == 660 || x == 661 || x == 758 || x == 759)) e.mode = MODE_ISLAND_GUARD;
    else if (isl && x >= 662 && x <= 757)                 e.mode = MODE_ISLAND_DATA;
    else if (nla && x >= 790 && x <= 797)                 e.mode = MODE_VIDEO_PREAMBLE;
    else if (nla && x >= 798)                             e.mode = MODE_VIDEO_GUARD;
    e.pe  = isl && (x == 661 || x == 693 || x == 725);
    e.ppc = (isl && x >= 662 && x <= 757) ? 5'((x - 662) % 32) : 5'd0;
    e.vfe = (x == 799) && (y == 524);
    return e;
  endfunction

  function automatic obs_t observed();
    return {mode, packet_enable, packet_pixel_counter, video_field_end};
  endfunction

  task automatic check_now(input string tag, input obs_t exp);
    obs_t act;
    act = observed();
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s got mode=%0d pe=%b ppc=%0d vfe=%b expected mode=%0d pe=%b ppc=%0d vfe=%b",
             tag, act.mode, act.pe, act.ppc, act.vfe, exp.mode, exp.pe, exp.ppc, exp.vfe);
    end
  endtask

  // Drives columns x0..x1 of line y; island_enable is high for x < ien_off.
  task automatic run_line(input int y, input int x0, input int x1, input bit isl, input int ien_off);
    obs_t exp, act;
    for (int x = x0; x <= x1; x++) begin
      @(negedge clk_pixel);
      cx = 10'(x);
      cy = 10'(y);
      island_enable = (x < ien_off);
      sb.push_back(model(x, y, isl));
      @(posedge clk_pixel);
      #1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $error("FAIL scoreboard_empty cy=%0d cx=%0d got size 0 expected 1", y, x);
      end else begin
        exp = sb.pop_front();
        act = observed();
        assert (act === exp) else begin
          n_fail++;
          $error("FAIL pixel cy=%0d cx=%0d got mode=%0d pe=%b ppc=%0d vfe=%b expected mode=%0d pe=%b ppc=%0d vfe=%b",
                 y, x, act.mode, act.pe, act.ppc, act.vfe, exp.mode, exp.pe, exp.ppc, exp.vfe);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1 check_now("reset_values", '0);
    @(negedge clk_pixel) reset_n = 1'b1;

    run_line(0,   0, 799, 1'b1, 9999);  // active line, video preamble for line 1
    run_line(479, 0, 799, 1'b1, 9999);  // last active line: no video preamble
    run_line(524, 0, 799, 1'b1, 9999);  // last frame line: preamble + field end
    run_line(500, 0, 799, 1'b0, 0);     // DVI line: blanking stays control

`ifdef HDMI_ISLAND_STATS_EN
    n_tests++;
    assert (island_packet_count === 16'd9) else begin
      n_fail++;
      $error("FAIL stats_count got %0d expected 9", island_packet_count);
    end
`endif

    run_line(501, 0, 799, 1'b1, 700);   // enable dropped mid-island: island completes
    run_line(502, 0, 699, 1'b1, 9999);

    // asynchronous reset in the middle of the data period
    @(negedge clk_pixel);
    cx = 10'd700;
    reset_n = 1'b0;
    #1 check_now("reset_async", '0);
    sb.delete();
    for (int x = 701; x <= 710; x++) begin
      @(negedge clk_pixel);
      cx = 10'(x);
    end
    @(posedge clk_pixel);
    #1 check_now("reset_hold", '0);
    @(negedge clk_pixel) reset_n = 1'b1;
    run_line(502, 711, 799, 1'b0, 9999); // rest of line: island gone
    run_line(503, 0, 799, 1'b1, 9999);   // next island at column 652

    n_tests++;
    assert (narrow_bad == 0) else begin
      n_fail++;
      $error("FAIL narrow_no_island got %0d bad cycles expected 0", narrow_bad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
